// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes and datapath mux selects.
package mc_ctrl_pkg;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9;
  localparam logic [3:0] ST_IMMEX  = 4'd10;
  localparam logic [3:0] ST_IMMWB  = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: clears on request, counts while enabled, flags when it reaches TIMEOUT_CYCLES-1.
module mc_wait_timer
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CNT_W'(1);
  end

  assign hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with bounded memory-ready wait; MULTICYCLE_CTRL_ADDI_EN enables the addi path.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       mem_err,
  output logic [3:0] state_o
);

  logic [3:0] state, state_nxt;
  logic [5:0] op_q;
  logic       wait_st, hit, timeout;

  assign wait_st = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
  assign timeout = wait_st && hit && !mem_ready;

  // Counter restarts on every state change and after a timeout that re-enters FETCH.
  mc_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr ((state_nxt != state) || timeout),
    .en  (wait_st && !mem_ready),
    .hit (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE)
        op_q <= opcode;
    end
  end

  always_comb begin
    state_nxt = ST_FETCH;
    case (state)
      ST_FETCH:  state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:        state_nxt = ST_EXEC;
          OP_LW, OP_SW:    state_nxt = ST_MEMADR;
          OP_BEQ:          state_nxt = ST_BRANCH;
          OP_J:            state_nxt = ST_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
          OP_ADDI:         state_nxt = ST_IMMEX;
`endif
          default:         state_nxt = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_nxt = (op_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_nxt = mem_ready ? ST_MEMWB : (timeout ? ST_FETCH : ST_MEMRD);
      ST_MEMWB:  state_nxt = ST_FETCH;
      ST_MEMWR:  state_nxt = (mem_ready || timeout) ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_nxt = ST_ALUWB;
      ST_ALUWB:  state_nxt = ST_FETCH;
      ST_BRANCH: state_nxt = ST_FETCH;
      ST_JUMP:   state_nxt = ST_FETCH;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ST_IMMEX:  state_nxt = ST_IMMWB;
      ST_IMMWB:  state_nxt = ST_FETCH;
`endif
      default:   state_nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALUOP_ADD;
    PCSource    = PCSRC_ALU;
    case (state)
      ST_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_4;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      ST_DECODE: ALUSrcB = SRCB_IMM2;
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ST_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      ST_MEMWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        MemtoReg = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      ST_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      ST_ALUWB: RegWrite = 1'b1;
      ST_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ST_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      ST_IMMWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign mem_err = timeout;
  assign state_o = state;

endmodule
